// File: rtl/timer_pkg.sv
// timer_pkg
//   Shared definitions for the timing blocks (microsecond delay timer and
//   its neighbours).
//   Contents:
//     state_t       FSM state encoding {IDLE, RUN, DONE}
//     CLK_FREQ_MHZ  system clock frequency in MHz; the tick generator
//                   divides by this to get its 1 us pulse
package timer_pkg;

  localparam int CLK_FREQ_MHZ = 36;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/us_delay_timer.sv
// us_delay_timer
//   Programmable one-shot microsecond delay. While a delay runs, o_timer_en
//   enables the neighbouring 1 us tick generator, and each tick counts
//   o_remaining down. Completion is flagged with a one-cycle o_done pulse.
//   All outputs are registered.
//
// Optional feature (macro PERIODIC_EN):
//   Adds i_periodic, latched with i_start. A periodic run reloads the
//   latched delay on its terminal tick, pulses o_done and keeps running
//   until i_abort or reset. A periodic start with delay 0 acts as one-shot.
//
// Ports:
//   i_clk_36MHz  in   system clock
//   i_reset      in   synchronous active-high reset
//   i_tick_1us   in   single-cycle 1 us tick from the tick generator
//   i_start      in   start request pulse, honoured only in IDLE
//   i_abort      in   cancel a running delay (wins over start and tick)
//   i_periodic   in   (PERIODIC_EN only) repeat the delay until aborted
//   i_delay_us   in   delay length in us, captured when start is accepted
//   o_timer_en   out  tick generator enable, high only in RUN
//   o_busy       out  high whenever the FSM is not IDLE
//   o_done       out  one-cycle completion pulse
//   o_remaining  out  microseconds still to elapse
module us_delay_timer
  import timer_pkg::*;
#(
  parameter int DELAY_WIDTH = 16
) (
  input  logic                   i_clk_36MHz,
  input  logic                   i_reset,
  input  logic                   i_tick_1us,
  input  logic                   i_start,
  input  logic                   i_abort,
`ifdef PERIODIC_EN
  input  logic                   i_periodic,
`endif
  input  logic [DELAY_WIDTH-1:0] i_delay_us,
  output logic                   o_timer_en,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [DELAY_WIDTH-1:0] o_remaining
);

  state_t                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] remaining_q, remaining_d;
  logic                   done_q, done_d;
  logic                   timer_en_q, timer_en_d;
  logic                   busy_q, busy_d;
`ifdef PERIODIC_EN
  logic                   periodic_q, periodic_d;
  logic [DELAY_WIDTH-1:0] reload_q, reload_d;
`endif

  // Next-state logic. Output flops are loaded from the next state so they
  // line up with the state register instead of lagging it by a cycle.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
`ifdef PERIODIC_EN
    periodic_d  = periodic_q;
    reload_d    = reload_q;
`endif
    case (state_q)
      IDLE: begin
        // Abort beats a simultaneous start; the start is simply dropped.
        if (i_start && !i_abort) begin
          if (i_delay_us != '0) begin
            state_d     = RUN;
            remaining_d = i_delay_us;
          end else begin
            state_d     = DONE;
            remaining_d = '0;
          end
`ifdef PERIODIC_EN
          periodic_d = i_periodic;
          reload_d   = i_delay_us;
`endif
        end
      end
      RUN: begin
        if (i_abort) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (i_tick_1us && remaining_q != '0) begin
          // The zero guard keeps the counter from ever wrapping.
          if (remaining_q == DELAY_WIDTH'(1)) begin
`ifdef PERIODIC_EN
            if (periodic_q) begin
              remaining_d = reload_q;
              done_d      = 1'b1;
            end else begin
              state_d     = DONE;
              remaining_d = '0;
            end
`else
            state_d     = DONE;
            remaining_d = '0;
`endif
          end else begin
            remaining_d = remaining_q - DELAY_WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
    if (state_d == DONE) begin
      done_d = 1'b1;
    end
    timer_en_d = (state_d == RUN);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge i_clk_36MHz) begin
    if (i_reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      done_q      <= 1'b0;
      timer_en_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PERIODIC_EN
      periodic_q  <= 1'b0;
      reload_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      timer_en_q  <= timer_en_d;
      busy_q      <= busy_d;
`ifdef PERIODIC_EN
      periodic_q  <= periodic_d;
      reload_q    <= reload_d;
`endif
    end
  end

  assign o_timer_en  = timer_en_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_remaining = remaining_q;

endmodule

// File: tb/tb_us_delay_timer.sv
// tb_us_delay_timer
//   Drives us_delay_timer with directed scenarios and random traffic and
//   compares every output, every cycle, against a behavioural model.
//   Build with +define+PERIODIC_EN to also exercise the periodic mode.
module tb_us_delay_timer;

  localparam int DW       = 16;
  // Scaled-down stand-in for the 36-cycle 1 us divider to keep runs short.
  localparam int TICK_DIV = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic          periodic;
  logic [DW-1:0] delay;
  logic          tickRand;
  logic          useGen;
  logic          genTick;
  logic          tick;
  logic          timerEn;
  logic          busy;
  logic          done;
  logic [DW-1:0] remaining;
  int            genCnt;

  int checkCount = 0;
  int errorCount = 0;

  // Behavioural model: a run is "running" with a microsecond count, or
  // "finishing" for the single done cycle.
  bit mRun, mFin, mPer, mPulse;
  int mRem, mReload;

  us_delay_timer #(.DELAY_WIDTH(DW)) dut (
    .i_clk_36MHz (clk),
    .i_reset     (reset),
    .i_tick_1us  (tick),
    .i_start     (start),
    .i_abort     (abort),
`ifdef PERIODIC_EN
    .i_periodic  (periodic),
`endif
    .i_delay_us  (delay),
    .o_timer_en  (timerEn),
    .o_busy      (busy),
    .o_done      (done),
    .o_remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick generator model: phase restarts whenever its enable is low.
  always @(posedge clk) begin
    if (!timerEn) genCnt <= 0;
    else genCnt <= (genCnt == TICK_DIV - 1) ? 0 : genCnt + 1;
  end
  assign genTick = timerEn && (genCnt == TICK_DIV - 1);
  assign tick    = useGen ? genTick : tickRand;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees.
  task automatic modelStep();
    mPulse = 1'b0;
    if (reset) begin
      mRun = 0; mFin = 0; mRem = 0;
    end else if (mFin) begin
      mFin = 0;
    end else if (mRun) begin
      if (abort) begin
        mRun = 0; mRem = 0;
      end else if (tick) begin
        mRem = mRem - 1;
        if (mRem == 0) begin
          if (mPer) begin
            mRem = mReload; mPulse = 1;
          end else begin
            mRun = 0; mFin = 1;
          end
        end
      end
    end else if (start && !abort) begin
      mReload = int'(delay);
`ifdef PERIODIC_EN
      mPer = periodic;
`else
      mPer = 0;
`endif
      if (delay == 0) mFin = 1;
      else begin
        mRun = 1; mRem = int'(delay);
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("timer_en", 32'(timerEn), 32'(mRun));
    checkOutput("busy", 32'(busy), 32'(mRun | mFin));
    checkOutput("done", 32'(done), 32'(mFin | mPulse));
    checkOutput("remaining", 32'(remaining), 32'(mRem));
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic setIdleInputs();
    reset = 0; start = 0; abort = 0; periodic = 0; tickRand = 0;
  endtask

  task automatic startRun(input int d, input bit per);
    start = 1; delay = DW'(d); periodic = per;
    applyStimulus();
    start = 0; periodic = 0;
  endtask

  // Run until the model is idle; returns the number of done cycles seen.
  task automatic runToIdle(input int budget, output int doneSeen);
    doneSeen = 0;
    for (int i = 0; i < budget && (mRun || mFin); i++) begin
      applyStimulus();
      if (done) doneSeen++;
    end
    checkOutput("idle_within_budget", 32'(mRun | mFin), 32'd0);
  endtask

  // Wait for the n-th tick to be presented; leaves it pending for the next edge.
  task automatic waitTick(input int n);
    int seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      if (tick) seen++;
      if (seen < n) applyStimulus();
    end
    checkOutput("tick_reached", 32'(seen), 32'(n));
  endtask

  initial begin
    int doneSeen;
    int remTrace[$];
    mRun = 0; mFin = 0; mPer = 0; mRem = 0; mReload = 0; mPulse = 0;
    setIdleInputs();
    delay = '0; useGen = 0;
    reset = 1;

    // Reset held three cycles; outputs must all read zero.
    repeat (3) applyStimulus();
    reset = 0;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_remaining", 32'(remaining), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tickRand = 1'(i & 1);
      applyStimulus();
    end
    checkOutput("idle_tick_remaining", 32'(remaining), 32'd0);
    setIdleInputs();

    // One-shot delay of 5 with the tick generator: 5,4,3,2,1,0.
    useGen = 1;
    startRun(5, 0);
    remTrace.push_back(int'(remaining));
    doneSeen = 0;
    for (int i = 0; i < 100 && (mRun || mFin); i++) begin
      applyStimulus();
      if (done) doneSeen++;
      if (int'(remaining) != remTrace[$]) remTrace.push_back(int'(remaining));
    end
    checkOutput("oneshot_done_cycles", 32'(doneSeen), 32'd1);
    checkOutput("oneshot_trace_len", 32'(remTrace.size()), 32'd6);
    for (int i = 0; i < remTrace.size() && i < 6; i++)
      checkOutput("oneshot_trace", 32'(remTrace[i]), 32'(5 - i));
    applyStimulus();

    // Zero delay: a single done pulse, enable never raised.
    startRun(0, 0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_en", 32'(timerEn), 32'd0);
    runToIdle(10, doneSeen);
    checkOutput("zero_done_cycles", 32'(doneSeen), 32'd0);

    // Abort coinciding with the 4th tick.
    startRun(10, 0);
    waitTick(4);
    abort = 1;
    applyStimulus();
    abort = 0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_remaining", 32'(remaining), 32'd0);
    checkOutput("abort_no_done", 32'(done), 32'd0);

    // Abort and start together in IDLE: start dropped.
    abort = 1; start = 1; delay = 7;
    applyStimulus();
    setIdleInputs();
    checkOutput("abort_start_busy", 32'(busy), 32'd0);

    // Start while busy is ignored; done after the original 8 ticks.
    startRun(8, 0);
    waitTick(2);
    start = 1; delay = 3;
    applyStimulus();
    start = 0;
    runToIdle(200, doneSeen);
    checkOutput("busy_start_done", 32'(doneSeen), 32'd1);

    // Reset at the 4th tick: silent abort.
    startRun(8, 0);
    waitTick(4);
    reset = 1;
    applyStimulus();
    reset = 0;
    checkOutput("reset_run_busy", 32'(busy), 32'd0);
    checkOutput("reset_run_done", 32'(done), 32'd0);

`ifdef PERIODIC_EN
    // Periodic delay of 3: four done pulses with enable held high, then abort.
    startRun(3, 1);
    doneSeen = 0;
    for (int i = 0; i < 200 && doneSeen < 4; i++) begin
      applyStimulus();
      if (done) doneSeen++;
      checkOutput("periodic_en_high", 32'(timerEn), 32'd1);
    end
    checkOutput("periodic_done_count", 32'(doneSeen), 32'd4);
    abort = 1;
    applyStimulus();
    abort = 0;
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (done) doneSeen++;
    end
    checkOutput("periodic_abort_done", 32'(doneSeen), 32'd0);
`endif

    // Random traffic with random ticks, starts, aborts and rare resets.
    useGen = 0;
    for (int i = 0; i < 4000; i++) begin
      tickRand = ($urandom_range(0, 2) == 0);
      start    = ($urandom_range(0, 5) == 0);
      abort    = ($urandom_range(0, 24) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      periodic = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) delay = DW'($urandom);
      else delay = DW'($urandom_range(0, 6));
      applyStimulus();
    end
    setIdleInputs();
    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
